cs_window_ctrl: RTL and testbench

//  Sequencer for the series-computation (CS) datapath: 9-sample sliding window of 8-bit X.

---
 rtl/cs_window_ctrl.sv | 148 ++++++++++++++
 tb/tb_cs_window_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cs_window_ctrl.sv
// cs_window_ctrl: sequencer for the series-computation datapath.
// Keeps a WIN-deep sliding window of samples together with its running sum.
// Once the window is full, every accepted sample starts a serial scan for X_appr.
// X_appr is the largest window entry that is <= floor(sum/WIN).
// Y = (sum + WIN*X_appr) >> SHIFT is then presented over a valid/ready handshake.
// Optional feature: define CS_FLUSH_EN to add a flush input.
// flush clears the window and abandons any scan or pending result.
module cs_window_ctrl #(
  parameter int DW    = 8,
  parameter int WIN   = 9,
  parameter int SHIFT = 3,
  parameter int SW    = 12,
  parameter int OW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] X,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] Y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          win_full,
  output logic          busy
`ifdef CS_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int CW = $clog2(WIN + 1);
  // OW+SHIFT bits are needed so that the pre-shift sum (up to 2*WIN*(2^DW-1)) never wraps.
  localparam int YW = OW + SHIFT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [DW-1:0] r_buf [WIN];
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_fill;
  logic [CW-1:0] r_idx;
  logic [SW-1:0] r_sum;
  logic [DW-1:0] r_xappr;
  logic [OW-1:0] r_y;

  logic          w_flush;
  logic          w_accept;
  logic          w_fullAfter;
  logic          w_scanLast;
  logic          w_candidate;
  logic [PW-1:0] w_scanIdx;
  logic [DW-1:0] w_scanVal;
  logic [SW-1:0] w_scaled;
  logic [YW-1:0] w_ySum;
  logic [OW-1:0] w_yOut;

`ifdef CS_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_accept    = in_valid && in_ready;
  assign w_fullAfter = (r_fill >= CW'(WIN - 1));
  // Scan steps 0..WIN-1 compare entries; the extra step WIN only forms Y from the finished maximum,
  // which keeps the multiply-add off the compare path.
  assign w_scanLast  = (r_idx == CW'(WIN));
  assign w_scanIdx   = (r_idx < CW'(WIN)) ? r_idx[PW-1:0] : '0;
  assign w_scanVal   = r_buf[w_scanIdx];
  assign w_scaled    = SW'(WIN) * SW'(w_scanVal);
  assign w_candidate = (w_scaled <= r_sum);
  assign w_ySum      = YW'(r_sum) + YW'(WIN) * YW'(r_xappr);
  assign w_yOut      = OW'(w_ySum >> SHIFT);

  // State register: reset always returns to IDLE, dropping any scan or pending result.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic: flush overrides everything, otherwise IDLE -> SCAN -> OUT -> IDLE.
  always_comb begin
    w_nextState = r_state;
    if (w_flush) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept && w_fullAfter) w_nextState = SCAN;
        SCAN:    if (w_scanLast)              w_nextState = OUT;
        OUT:     if (out_ready)               w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Output decode: handshake flags follow the state directly, Y is the held result register.
  always_comb begin
    in_ready  = (r_state == IDLE) && !w_flush;
    out_valid = (r_state == OUT);
    busy      = (r_state != IDLE);
    win_full  = (r_fill == CW'(WIN));
    Y         = r_y;
  end

  // Window, running sum and scan datapath: updated on accept in IDLE and stepped during SCAN.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) r_buf[i] <= '0;
      r_wptr  <= '0;
      r_fill  <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_xappr <= '0;
      r_y     <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < WIN; i++) r_buf[i] <= '0;
      r_wptr  <= '0;
      r_fill  <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_xappr <= '0;
    end else begin
      if (w_accept) begin
        r_buf[r_wptr] <= X;
        r_sum         <= r_sum + SW'(X) - SW'(r_buf[r_wptr]);
        r_wptr        <= (r_wptr == PW'(WIN - 1)) ? '0 : r_wptr + 1'b1;
        if (r_fill != CW'(WIN)) r_fill <= r_fill + 1'b1;
        r_idx   <= '0;
        r_xappr <= '0;
      end
      if (r_state == SCAN) begin
        if (w_scanLast) begin
          r_y <= w_yOut;
        end else begin
          r_idx <= r_idx + 1'b1;
          if (w_candidate && (w_scanVal > r_xappr)) r_xappr <= w_scanVal;
        end
      end
    end
  end

endmodule

// File: tb/tb_cs_window_ctrl.sv
// tb_cs_window_ctrl: directed, self-checking bench for cs_window_ctrl.
// Table-driven sample sequences plus hand-written handshake, reset and flush corner cases.
// The flush sequence is only built when CS_FLUSH_EN is defined.
module tb_cs_window_ctrl;

  localparam int WIN = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] X;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] Y;
  logic       out_valid;
  logic       out_ready;
  logic       win_full;
  logic       busy;
`ifdef CS_FLUSH_EN
  logic       flush;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       doReset;
    logic [7:0] x;
    logic       expOut;
    logic [9:0] expY;
    logic       expFull;
  } vec_t;

  vec_t vecs[$];

  cs_window_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .X         (X),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .win_full  (win_full),
    .busy      (busy)
`ifdef CS_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Watchdog so that a stuck design still ends the run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
  endtask

  // Offer one sample, then check win_full and either the result (with exact latency) or idleness.
  task automatic applyStimulus(input logic [7:0] x, input logic expOut, input logic [9:0] expY,
                               input logic expFull, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput({tag, " in_ready_timeout"}, 0, 1);
      return;
    end
    X        = x;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, " win_full"}, int'(win_full), int'(expFull));
    if (expOut) begin
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput({tag, " latency"}, n, WIN + 1);
      checkOutput({tag, " Y"}, int'(Y), int'(expY));
    end else begin
      checkOutput({tag, " busy"}, int'(busy), 0);
      checkOutput({tag, " out_valid"}, int'(out_valid), 0);
    end
  endtask

  task automatic addVec(input logic doRst, input logic [7:0] x, input logic expOut,
                        input logic [9:0] expY, input logic expFull);
    vec_t v;
    v.doReset = doRst;
    v.x       = x;
    v.expOut  = expOut;
    v.expY    = expY;
    v.expFull = expFull;
    vecs.push_back(v);
  endtask

  initial begin
    int tailY[9];
    reset     = 1'b1;
    X         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef CS_FLUSH_EN
    flush     = 1'b0;
`endif

    // Nine equal samples: one Y = (90+90)>>3 = 22 on the ninth.
    for (int i = 0; i < 9; i++)
      addVec(i == 0, 8'h0A, i == 8, (i == 8) ? 10'd22 : 10'd0, i == 8);
    // Ramp 1..9: sum 45, X_appr 5 -> 11; then 10 slides the window to 2..10: sum 54, X_appr 6 -> 13.
    for (int i = 0; i < 9; i++)
      addVec(i == 0, 8'(i + 1), i == 8, (i == 8) ? 10'd11 : 10'd0, i == 8);
    addVec(1'b0, 8'h0A, 1'b1, 10'd13, 1'b1);
    // Full-scale window: sum 2295, Y = 4590>>3 = 573; zeros then replace entries one at a time.
    for (int i = 0; i < 9; i++)
      addVec(i == 0, 8'hFF, i == 8, (i == 8) ? 10'd573 : 10'd0, i == 8);
    tailY = '{255, 223, 191, 159, 127, 95, 63, 31, 0};
    for (int i = 0; i < 9; i++)
      addVec(1'b0, 8'h00, 1'b1, 10'(tailY[i]), 1'b1);

    resetDut();
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset win_full", int'(win_full), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset Y", int'(Y), 0);

    foreach (vecs[i]) begin
      if (vecs[i].doReset) resetDut();
      applyStimulus(vecs[i].x, vecs[i].expOut, vecs[i].expY, vecs[i].expFull, $sformatf("vec%0d", i));
    end

    // Sink stalls for 5 cycles: result held, input blocked, offered sample not consumed.
    resetDut();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      applyStimulus(8'h0A, i == 8, 10'd22, i == 8, $sformatf("stall%0d", i));
    for (int k = 0; k < 5; k++) begin
      X        = 8'h55;
      in_valid = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("stall hold%0d out_valid", k), int'(out_valid), 1);
      checkOutput($sformatf("stall hold%0d Y", k), int'(Y), 22);
      checkOutput($sformatf("stall hold%0d in_ready", k), int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall release out_valid", int'(out_valid), 0);
    checkOutput("stall release in_ready", int'(in_ready), 1);
    checkOutput("stall release Y kept", int'(Y), 22);
    applyStimulus(8'h0A, 1'b1, 10'd22, 1'b1, "stall after");

    // Reset in the middle of a scan abandons it and restarts the window.
    resetDut();
    for (int i = 0; i < 8; i++)
      applyStimulus(8'h0C, 1'b0, 10'd0, 1'b0, $sformatf("midrst pre%0d", i));
    X        = 8'h0C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("midrst scanning busy", int'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst out_valid", int'(out_valid), 0);
    checkOutput("midrst in_ready", int'(in_ready), 1);
    checkOutput("midrst win_full", int'(win_full), 0);
    checkOutput("midrst busy", int'(busy), 0);
    for (int i = 0; i < 8; i++)
      applyStimulus(8'h08, 1'b0, 10'd0, 1'b0, $sformatf("midrst post%0d", i));
    applyStimulus(8'h08, 1'b1, 10'd18, 1'b1, "midrst ninth");

`ifdef CS_FLUSH_EN
    // Flush with a simultaneous sample: sample dropped, window restarts from empty.
    resetDut();
    for (int i = 0; i < 12; i++)
      applyStimulus(8'h0A, i >= 8, 10'd22, i >= 8, $sformatf("flush pre%0d", i));
    X        = 8'hFF;
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    checkOutput("flush in_ready", int'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    checkOutput("flush win_full", int'(win_full), 0);
    checkOutput("flush busy", int'(busy), 0);
    checkOutput("flush Y kept", int'(Y), 22);
    for (int i = 0; i < 9; i++)
      applyStimulus(8'h14, i == 8, 10'd45, i == 8, $sformatf("flush post%0d", i));
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
